// File: rtl/sgdmac_pkg.sv
// Shared types for the SGDMAC AXI read multiplexer: FSM state encoding,
// downstream ID width and the per-master AR control bundle.
// Latency: n/a (types only). Backpressure: n/a.
package sgdmac_pkg;

   // Downstream ARID/RID width; the grant index is carried in this field.
   localparam int ID_W = 4;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   // AR control fields of one master. The address lives outside the struct
   // because its width is a module parameter.
   typedef struct packed {
      logic [3:0] len;
      logic [2:0] size;
      logic [1:0] burst;
   } ar_req_t;

endpackage

// File: rtl/sgdmac_rr_picker.sv
// Round-robin find-first: picks the first set request bit after 'last'.
// Latency: combinational. Backpressure: none, pure function of inputs.
// Ports: req (request vector), last (previous winner) -> gnt (winner), gnt_vld.
module sgdmac_rr_picker #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [IW-1:0] gnt,
   output logic          gnt_vld
);

   logic [IW-1:0] idx;

   // Walk from the farthest candidate (last itself) to the nearest
   // (last+1) so the nearest requester overwrites any earlier hit.
   always_comb begin
      gnt     = last;
      gnt_vld = 1'b0;
      idx     = '0;
      for (int i = N; i >= 1; i--) begin
         idx = IW'((int'(last) + i) % N);
         if (req[idx]) begin
            gnt     = idx;
            gnt_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sgdmac_axi_rd_mux.sv
// N-master AXI read mux: round-robin AR arbitration, R routed back by RID.
// Latency: grant registered, arvalid_o one cycle after a winner is seen; at most one AR per 2 cycles.
// Backpressure: AR grant and fields held while arready_i=0; R ready taken from the addressed master.
// Ports: m_ar*_i/m_arvalid_i/m_arready_o per-master AR; m_rvalid_o/m_rready_i per-master R
//        handshake; ar*_o/arvalid_o/arready_i downstream AR; rid_i/rlast_i/rvalid_i/rready_o
//        downstream R; bad_rid_o sticky unknown-RID flag; idle_o nothing in flight.
// Build option: define SGDMAC_OUTST_LIMIT_EN to cap outstanding bursts per master at MAX_OUTST.
module sgdmac_axi_rd_mux
   import sgdmac_pkg::*;
#(
   parameter int N_MASTER  = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_OUTST = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_MASTER*ADDR_W-1:0] m_araddr_i,
   input  logic [N_MASTER*4-1:0]      m_arlen_i,
   input  logic [N_MASTER*3-1:0]      m_arsize_i,
   input  logic [N_MASTER*2-1:0]      m_arburst_i,
   input  logic [N_MASTER-1:0]        m_arvalid_i,
   output logic [N_MASTER-1:0]        m_arready_o,
   output logic [N_MASTER-1:0]        m_rvalid_o,
   input  logic [N_MASTER-1:0]        m_rready_i,
   output logic [ID_W-1:0]            arid_o,
   output logic [ADDR_W-1:0]          araddr_o,
   output logic [3:0]                 arlen_o,
   output logic [2:0]                 arsize_o,
   output logic [1:0]                 arburst_o,
   output logic                       arvalid_o,
   input  logic                       arready_i,
   input  logic [ID_W-1:0]            rid_i,
   input  logic                       rlast_i,
   input  logic                       rvalid_i,
   output logic                       rready_o,
   output logic                       bad_rid_o,
   output logic                       idle_o
);

   localparam int GW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

   state_t                state;
   // Current grant; it also serves as the round-robin pointer, hence the
   // reset value N_MASTER-1 so that master 0 is searched first.
   logic [GW-1:0]         grant;
   logic [GW-1:0]         pick;
   logic                  pick_vld;
   logic [N_MASTER-1:0]   elig;
   logic                  ar_hs;
   logic                  rid_ok;

   logic [ADDR_W-1:0]     addr_arr [N_MASTER];
   ar_req_t               req_arr  [N_MASTER];
   ar_req_t               req_sel;

   for (genvar k = 0; k < N_MASTER; k++) begin : g_unpack
      assign addr_arr[k]       = m_araddr_i[k*ADDR_W +: ADDR_W];
      assign req_arr[k].len    = m_arlen_i[k*4 +: 4];
      assign req_arr[k].size   = m_arsize_i[k*3 +: 3];
      assign req_arr[k].burst  = m_arburst_i[k*2 +: 2];
   end

   sgdmac_rr_picker #(.N(N_MASTER), .IW(GW)) u_picker (
      .req     (elig),
      .last    (grant),
      .gnt     (pick),
      .gnt_vld (pick_vld)
   );

   // ---------------- AR channel ----------------
   assign arvalid_o = (state == ST_ISSUE);
   assign ar_hs     = arvalid_o & arready_i;
   assign req_sel   = req_arr[grant];
   assign araddr_o  = addr_arr[grant];
   assign arlen_o   = req_sel.len;
   assign arsize_o  = req_sel.size;
   assign arburst_o = req_sel.burst;
   assign arid_o    = ID_W'(grant);

   always_comb begin
      m_arready_o        = '0;
      m_arready_o[grant] = ar_hs;
   end

   // Winner is only taken in IDLE; in ISSUE the grant is frozen until the
   // downstream accepts, whatever the other masters do.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         grant <= GW'(N_MASTER - 1);
      end else if (state == ST_IDLE) begin
         if (pick_vld) begin
            state <= ST_ISSUE;
            grant <= pick;
         end
      end else if (arready_i) begin
         state <= ST_IDLE;
      end
   end

   // ---------------- R channel ----------------
   assign rid_ok = ({1'b0, rid_i} < 5'(N_MASTER));

   // Unknown RIDs are drained (rready_o=1) so a stray beat cannot wedge the bus.
   always_comb begin
      m_rvalid_o = '0;
      rready_o   = 1'b1;
      for (int k = 0; k < N_MASTER; k++) begin
         if (rid_i == ID_W'(k)) begin
            m_rvalid_o[k] = rvalid_i;
            rready_o      = m_rready_i[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bad_rid_o <= 1'b0;
      end else if (rvalid_i & ~rid_ok) begin
         bad_rid_o <= 1'b1;
      end
   end

   // ---------------- Outstanding tracking ----------------
`ifdef SGDMAC_OUTST_LIMIT_EN
   localparam int CW = $clog2(MAX_OUTST + 1);

   logic [N_MASTER-1:0] full;
   logic [N_MASTER-1:0] busy;

   for (genvar k = 0; k < N_MASTER; k++) begin : g_cnt
      logic [CW-1:0] cnt;
      logic          inc;
      logic          dec;

      assign inc = ar_hs & (grant == GW'(k));
      assign dec = rvalid_i & rready_o & rlast_i & (rid_i == ID_W'(k));

      // A burst issued and one completed in the same cycle cancel out.
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt <= '0;
         end else if (inc & ~dec) begin
            cnt <= cnt + CW'(1);
         end else if (dec & ~inc) begin
            cnt <= cnt - CW'(1);
         end
      end

      assign full[k] = (cnt == CW'(MAX_OUTST));
      assign busy[k] = (cnt != '0);
   end

   assign elig   = m_arvalid_i & ~full;
   assign idle_o = ~arvalid_o & ~(|busy);
`else
   logic unused_cfg;

   assign elig       = m_arvalid_i;
   assign idle_o     = ~arvalid_o;
   assign unused_cfg = rlast_i ^ (MAX_OUTST > 0);
`endif

endmodule
